// File: rtl/imem_boot_loader.sv
// Byte-stream program loader for the MIPS instruction memory; holds cpu_rst until a full image is written.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module imem_boot_loader #(
  parameter int ADDR_W     = 8,
  parameter int BASE_ADDR  = 0,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              cpu_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W:0]   words_loaded_o
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] HDR_HI = 3'd1;
  localparam logic [2:0] HDR_LO = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERR    = 3'd6;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] CHK    = 3'd7;
  localparam logic [2:0] FINISH = CHK;
`else
  localparam logic [2:0] FINISH = DONE;
`endif

  localparam logic [31:0]       MAX_WORDS = 32'((1 << ADDR_W) - BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  logic [2:0]        state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              cpu_rst_q, cpu_rst_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic            accept;
  logic            start_ok;
  logic [15:0]     n_full;
  logic [ADDR_W:0] words_next;

  assign rx_ready_o = (state_q == HDR_HI) || (state_q == HDR_LO) || (state_q == DATA)
`ifdef LOADER_CHECKSUM_EN
                      || (state_q == CHK)
`endif
                      ;
  assign accept     = rx_valid_i && rx_ready_o;
  assign start_ok   = start_i && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
  assign n_full     = {n_q[15:8], rx_data_i};
  assign words_next = words_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    bcnt_d    = bcnt_q;
    wdata_d   = wdata_q;
    addr_d    = addr_q;
    words_d   = words_q;
    cpu_rst_d = cpu_rst_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    if (start_ok) begin
      state_d   = HDR_HI;
      bcnt_d    = 2'd0;
      addr_d    = BASE;
      words_d   = '0;
      cpu_rst_d = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      csum_d    = 8'd0;
`endif
    end else begin
      case (state_q)
        HDR_HI: if (accept) begin
          n_d[15:8] = rx_data_i;
          state_d   = HDR_LO;
        end
        HDR_LO: if (accept) begin
          n_d = n_full;
          // Range check here is what keeps mem_addr from wrapping during the data phase.
          if (n_full == 16'd0)                state_d = FINISH;
          else if (32'(n_full) > MAX_WORDS)   state_d = ERR;
          else                                state_d = DATA;
        end
        DATA: if (accept) begin
          if (BIG_ENDIAN) wdata_d = {wdata_q[23:0], rx_data_i};
          else            wdata_d = {rx_data_i, wdata_q[31:8]};
          bcnt_d = bcnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_data_i;
`endif
          if (bcnt_q == 2'd3) state_d = WRITE;
        end
        WRITE: begin
          addr_d  = addr_q + 1'b1;
          words_d = words_next;
          state_d = (32'(words_next) == 32'(n_q)) ? FINISH : DATA;
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: if (accept) state_d = (rx_data_i == csum_q) ? DONE : ERR;
`endif
        // Release the processor one cycle after done rises.
        DONE:    cpu_rst_d = 1'b0;
        IDLE:    ;
        ERR:     ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      n_q       <= 16'd0;
      bcnt_q    <= 2'd0;
      wdata_q   <= 32'd0;
      addr_q    <= BASE;
      words_q   <= '0;
      cpu_rst_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      csum_q    <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      bcnt_q    <= bcnt_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
      words_q   <= words_d;
      cpu_rst_q <= cpu_rst_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign mem_we_o       = (state_q == WRITE);
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign cpu_rst_o      = cpu_rst_q;
  assign busy_o         = (state_q != IDLE) && (state_q != DONE) && (state_q != ERR);
  assign done_o         = (state_q == DONE);
  assign error_o        = (state_q == ERR);
  assign words_loaded_o = words_q;

endmodule
